// File: rtl/seq_frame_pkg.sv
// Shared constants and state encoding for the 1011-sync serial frame transmitter
// and its matching stuffing monitor.
package seq_frame_pkg;

   localparam logic [3:0]  SYNC_PATTERN  = 4'b1011;
   localparam int unsigned SYNC_LEN      = 4;
   localparam logic [2:0]  STUFF_TRIGGER = 3'b101;
   // Last three line bits once the sync field has gone out.
   localparam logic [2:0]  SYNC_TAIL     = SYNC_PATTERN[2:0];

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC  = 3'd1,
      ST_DATA  = 3'd2,
      ST_STUFF = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

endpackage

// File: rtl/seq_stuff_mon.sv
// Three-bit line history; flags when the bit now on the line completes 101,
// meaning a zero must be stuffed next so 1011 cannot form.
module seq_stuff_mon
   import seq_frame_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic shift,
   input  logic bit_in,
   output logic stuff_req
);

   logic [2:0] history;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         history <= '0;
      end else if (load) begin
         history <= SYNC_TAIL;
      end else if (shift) begin
         history <= {history[1:0], bit_in};
      end
   end

   // bit_in is the bit currently on the line, so the check includes it.
   assign stuff_req = ({history[1:0], bit_in} == STUFF_TRIGGER);

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: 1011 sync, MSB-first payload with zero stuffing
// so 1011 never reappears, then a forced idle gap.
module seq_frame_tx
   import seq_frame_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int GAP_BITS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              tx_bit,
   output logic              tx_active,
   output logic              frame_done
);

   localparam int BCNT_W = $clog2(DATA_W + 1);
   localparam int GCNT_W = $clog2(GAP_BITS + 1);
   localparam logic [BCNT_W-1:0] BITS_LAST = BCNT_W'(DATA_W);
   localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
   localparam logic [GCNT_W-1:0] GAP_INIT  = GCNT_W'(GAP_BITS);
   localparam logic [GCNT_W-1:0] GAP_ONE   = GCNT_W'(1);
   localparam logic [1:0]        SYNC_LAST = 2'(SYNC_LEN - 1);
   localparam logic [1:0]        SYNC_ONE  = 2'd1;

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [BCNT_W-1:0] bit_cnt;
   logic [GCNT_W-1:0] gap_cnt;
   logic [1:0]        sync_idx;
   logic              hs;
   logic              sync_end;
   logic              send_payload;
   logic              stuff_req;

   assign hs       = data_valid & data_ready;
   assign sync_end = (state == ST_SYNC) && (sync_idx == SYNC_LAST);
   // A payload bit is loaded onto the line at this edge.
   assign send_payload = sync_end
                      || ((state == ST_DATA) && !stuff_req && (bit_cnt != BITS_LAST))
                      || ((state == ST_STUFF) && (bit_cnt != BITS_LAST));

   seq_stuff_mon u_stuff_mon (
      .clk       (clk),
      .rst       (rst),
      .load      (sync_end),
      .shift     ((state == ST_DATA) || (state == ST_STUFF)),
      .bit_in    (tx_bit),
      .stuff_req (stuff_req)
   );

   always_ff @(posedge clk) begin
      if (hs) begin
         shreg <= data_in;
      end else if (send_payload) begin
         shreg <= {shreg[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_GAP;
         gap_cnt    <= GAP_INIT;
         sync_idx   <= '0;
         bit_cnt    <= '0;
         tx_bit     <= 1'b0;
         tx_active  <= 1'b0;
         data_ready <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (hs) begin
                  state      <= ST_SYNC;
                  sync_idx   <= '0;
                  bit_cnt    <= '0;
                  tx_bit     <= SYNC_PATTERN[SYNC_LAST];
                  tx_active  <= 1'b1;
                  data_ready <= 1'b0;
               end
            end
            ST_SYNC: begin
               if (sync_end) begin
                  state   <= ST_DATA;
                  tx_bit  <= shreg[DATA_W-1];
                  bit_cnt <= bit_cnt + BCNT_ONE;
               end else begin
                  sync_idx <= sync_idx + SYNC_ONE;
                  tx_bit   <= SYNC_PATTERN[SYNC_LAST - sync_idx - SYNC_ONE];
               end
            end
            ST_DATA, ST_STUFF: begin
               if ((state == ST_DATA) && stuff_req) begin
                  state  <= ST_STUFF;
                  tx_bit <= 1'b0;
               end else if (send_payload) begin
                  state   <= ST_DATA;
                  tx_bit  <= shreg[DATA_W-1];
                  bit_cnt <= bit_cnt + BCNT_ONE;
               end else begin
                  state      <= ST_GAP;
                  gap_cnt    <= GAP_INIT;
                  tx_bit     <= 1'b0;
                  tx_active  <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_ONE) begin
                  state      <= ST_IDLE;
                  data_ready <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - GAP_ONE;
               end
            end
            default: begin
               state      <= ST_GAP;
               gap_cnt    <= GAP_INIT;
               tx_bit     <= 1'b0;
               tx_active  <= 1'b0;
               data_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
